// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//   Register-access front end for a byte-level I2C master. One request
//   (device, register, write data or read) is expanded into the ordered
//   start / write / read / stop command pulses. Each command waits for the
//   master's done. Slave NACKs and master timeouts are folded into one
//   error flag, which is returned together with the read byte.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req, req_*            request strobe and fields (sampled only when idle)
//   busy                  transaction in progress
//   rsp_valid/err/rdata   one-cycle completion pulse, status and read byte
//   m_start/stop/write/read  one-cycle command pulses to the master
//   m_data_in, m_ack_in   byte for write commands, ACK bit for the read
//   m_done, m_ack_err, m_data_out  master completion, NACK flag, read byte
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_write,
  output logic       m_read,
  output logic [7:0] m_data_in,
  output logic       m_ack_in,
  input  logic       m_done,
  input  logic       m_ack_err,
  input  logic [7:0] m_data_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last WAIT cycle before a timeout: the counter value that, once
  // incremented, reaches TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [2:0] {
    PH_START, PH_ADDR_W, PH_REG, PH_WDATA, PH_RSTART, PH_ADDR_R, PH_RDATA, PH_STOP
  } phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       regaddr_q, regaddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             nack;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_START;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      regaddr_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      data_q      <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      regaddr_q   <= regaddr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    regaddr_d   = regaddr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    nack        = 1'b0;
    m_start     = 1'b0;
    m_stop      = 1'b0;
    m_write     = 1'b0;
    m_read      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d   = ST_ISSUE;
          phase_d   = PH_START;
          rw_d      = req_rw;
          dev_d     = req_dev;
          regaddr_d = req_reg;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
        case (phase_q)
          PH_START, PH_RSTART: m_start = 1'b1;
          PH_STOP:             m_stop  = 1'b1;
          PH_RDATA:            m_read  = 1'b1;
          default:             m_write = 1'b1;
        endcase
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (m_done) begin
          state_d = ST_ISSUE;
          // Only the write phases carry a meaningful slave ACK.
          nack = m_ack_err && (phase_q inside {PH_ADDR_W, PH_REG, PH_WDATA, PH_ADDR_R});
          if (nack) begin
            err_d   = 1'b1;
            phase_d = PH_STOP;
          end else begin
            case (phase_q)
              PH_START:  phase_d = PH_ADDR_W;
              PH_ADDR_W: phase_d = PH_REG;
              PH_REG:    phase_d = rw_q ? PH_RSTART : PH_WDATA;
              PH_WDATA:  phase_d = PH_STOP;
              PH_RSTART: phase_d = PH_ADDR_R;
              PH_ADDR_R: phase_d = PH_RDATA;
              PH_RDATA: begin
                rdata_d = m_data_out;
                phase_d = PH_STOP;
              end
              default:   state_d = ST_RESP;
            endcase
          end
        end else if (cnt_q == CNT_LAST) begin
          // A silent master still gets a STOP attempt, unless STOP itself hung.
          err_d = 1'b1;
          if (phase_q == PH_STOP) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
            phase_d = PH_STOP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the outgoing byte on entry to ISSUE so it is stable for the whole
    // command, up to and including m_done.
    if (state_d == ST_ISSUE) begin
      case (phase_d)
        PH_ADDR_W: data_d = {dev_q, 1'b0};
        PH_REG:    data_d = regaddr_q;
        PH_WDATA:  data_d = wdata_q;
        PH_ADDR_R: data_d = {dev_q, 1'b1};
        default:   data_d = data_q;
      endcase
    end

    // Response registers change only on entry to RESP and then hold.
    if (state_d == ST_RESP) begin
      rsp_err_d   = err_d;
      rsp_rdata_d = (rw_q && !err_d) ? rdata_q : 8'h00;
    end

    busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    rsp_valid = (state_q == ST_RESP);
    m_ack_in  = busy && (phase_q == PH_RDATA);
  end

  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign m_data_in = data_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//   Directed bench for i2c_reg_sequencer with a small I2C master model.
//   Expected commands and responses are queued when a request is issued. Two
//   monitors compare every command pulse and every rsp_valid against them.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

  localparam int TO = 50;
  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_STOP  = 3'd2;
  localparam logic [2:0] C_WR    = 3'd3;
  localparam logic [2:0] C_RD    = 3'd4;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       busy, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       m_start, m_stop, m_write, m_read;
  logic [7:0] m_data_in;
  logic       m_ack_in;
  logic       m_done, m_ack_err;
  logic [7:0] m_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;

  logic [11:0] exp_cmd_q[$];
  rsp_t        exp_rsp_q[$];

  // Master model knobs, written only by the stimulus process.
  int         done_delay = 1;
  bit         silent = 1'b0;
  int         nack_at = 0;
  logic [7:0] rd_byte = 8'h00;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_rw     (req_rw),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .m_start    (m_start),
    .m_stop     (m_stop),
    .m_write    (m_write),
    .m_read     (m_read),
    .m_data_in  (m_data_in),
    .m_ack_in   (m_ack_in),
    .m_done     (m_done),
    .m_ack_err  (m_ack_err),
    .m_data_out (m_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] cmd(input logic [2:0] t, input logic ack, input logic [7:0] d);
    return {t, ack, d};
  endfunction

  task automatic exp_write_txn(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, {dev, 1'b0}));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, ra));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, wd));
    exp_cmd_q.push_back(cmd(C_STOP, 1'b0, 8'h00));
  endtask

  task automatic exp_read_txn(input logic [6:0] dev, input logic [7:0] ra);
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, {dev, 1'b0}));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, ra));
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, {dev, 1'b1}));
    exp_cmd_q.push_back(cmd(C_RD, 1'b1, 8'h00));
    exp_cmd_q.push_back(cmd(C_STOP, 1'b0, 8'h00));
  endtask

  task automatic exp_rsp(input logic err, input logic [7:0] rdata, input int lat);
    rsp_t r;
    r.err   = err;
    r.rdata = rdata;
    r.lat   = lat;
    exp_rsp_q.push_back(r);
  endtask

  // One-cycle request strobe; req_cyc is the edge that samples it.
  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    req       = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = ra;
    req_wdata = wd;
    req_cyc   = cyc + 1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && exp_rsp_q.size() == 0 && exp_cmd_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  // Cycle counter: number of rising edges so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Master model: answers each command done_delay cycles after its pulse.
  initial begin
    int   pend = 0;
    bit   pend_nack = 1'b0;
    int   wr_count = 0;
    m_done     = 1'b0;
    m_ack_err  = 1'b0;
    m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      m_done    = 1'b0;
      m_ack_err = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_done     = 1'b1;
          m_ack_err  = pend_nack;
          m_data_out = rd_byte;
        end
      end
      if (!busy) wr_count = 0;
      if (!reset && (m_start || m_stop || m_write || m_read) && !silent) begin
        pend      = done_delay;
        pend_nack = m_write && (wr_count + 1 == nack_at);
      end
      if (!reset && m_write) wr_count++;
    end
  end

  // Command monitor.
  initial forever begin
    logic [2:0]  t;
    logic [11:0] obs;
    logic [11:0] exp;
    @(negedge clk);
    if (!reset && (m_start || m_stop || m_write || m_read)) begin
      check("cmd_onehot", 32'($countones({m_start, m_stop, m_write, m_read})), 32'd1);
      t = m_start ? C_START : m_stop ? C_STOP : m_write ? C_WR : C_RD;
      obs = cmd(t, m_ack_in, m_write ? m_data_in : 8'h00);
      if (exp_cmd_q.size() == 0) begin
        check("cmd_unexpected", {20'd0, obs}, 32'd0);
      end else begin
        exp = exp_cmd_q.pop_front();
        check("cmd", {20'd0, obs}, {20'd0, exp});
      end
    end
  end

  // Response monitor.
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rsp_valid) begin
      check("rsp_busy_low", 32'(busy), 32'd0);
      if (exp_rsp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        if (e.lat >= 0) check("rsp_latency", 32'(cyc - req_cyc), 32'(e.lat));
      end
    end
  end

  initial begin
    reset = 1'b1; req = 1'b0; req_rw = 1'b0;
    req_dev = '0; req_reg = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_pulses", 32'({m_start, m_stop, m_write, m_read}), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    check("rst_m_ack_in", 32'(m_ack_in), 32'd0);
    reset = 1'b0;

    // Plain write: 5 phases of 2 cycles each.
    exp_write_txn(7'h27, 8'h10, 8'hA5);
    exp_rsp(1'b0, 8'h00, 10);
    issue(1'b0, 7'h27, 8'h10, 8'hA5);
    wait_done("write");

    // Plain read: 7 phases.
    rd_byte = 8'h71;
    exp_read_txn(7'h68, 8'h75);
    exp_rsp(1'b0, 8'h71, 14);
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    wait_done("read");
    repeat (3) @(negedge clk);
    check("hold_rdata", 32'(rsp_rdata), 32'h71);
    check("hold_err", 32'(rsp_err), 32'd0);

    // NACK on the address byte of a write.
    nack_at = 1;
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, 8'h4E));
    exp_cmd_q.push_back(cmd(C_STOP, 1'b0, 8'h00));
    exp_rsp(1'b1, 8'h00, 6);
    issue(1'b0, 7'h27, 8'h10, 8'hA5);
    wait_done("nack_addr");

    // NACK on the register byte of a read: no repeated start.
    nack_at = 2;
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, 8'hD0));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, 8'h75));
    exp_cmd_q.push_back(cmd(C_STOP, 1'b0, 8'h00));
    exp_rsp(1'b1, 8'h00, 8);
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    wait_done("nack_reg");
    nack_at = 0;

    // Silent master: START times out, then STOP times out.
    silent = 1'b1;
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_STOP, 1'b0, 8'h00));
    exp_rsp(1'b1, 8'h00, 2 * TO);
    issue(1'b0, 7'h27, 8'h10, 8'hA5);
    wait_done("timeout");
    silent = 1'b0;

    // Second request while busy must be dropped.
    rd_byte = 8'h3C;
    exp_read_txn(7'h68, 8'h75);
    exp_rsp(1'b0, 8'h3C, 14);
    issue(1'b1, 7'h68, 8'h75, 8'h00);
    repeat (3) @(negedge clk);
    req = 1'b1; req_rw = 1'b0; req_dev = 7'h11; req_reg = 8'h22; req_wdata = 8'h33;
    @(negedge clk);
    req = 1'b0;
    wait_done("busy_ignore");
    repeat (5) @(negedge clk);

    // Request held only in the RESP cycle must not start a transaction.
    exp_write_txn(7'h50, 8'h01, 8'hFF);
    exp_rsp(1'b0, 8'h00, 10);
    issue(1'b0, 7'h50, 8'h01, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    req = 1'b1; req_rw = 1'b0; req_dev = 7'h33; req_reg = 8'h44; req_wdata = 8'h55;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("resp_req_ignored", 32'(busy), 32'd0);

    // Reset while waiting on the register byte.
    done_delay = 5;
    exp_cmd_q.push_back(cmd(C_START, 1'b0, 8'h00));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, 8'h4E));
    exp_cmd_q.push_back(cmd(C_WR, 1'b0, 8'h10));
    issue(1'b0, 7'h27, 8'h10, 8'hA5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_cmd_q.size() == 0) break;
    end
    check("reg_cmd_seen", 32'(exp_cmd_q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_pulses", 32'({m_start, m_stop, m_write, m_read}), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    done_delay = 1;
    exp_write_txn(7'h27, 8'h10, 8'hA5);
    exp_rsp(1'b0, 8'h00, 10);
    issue(1'b0, 7'h27, 8'h10, 8'hA5);
    wait_done("post_reset_write");

    repeat (5) @(negedge clk);
    check("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Transaction-level controller directly upstream of the byte-level I2C master (start/stop/write/read command engine).
- Converts one register-access request (device address, register address, write data or read) into the ordered command pulses the master needs.
- Sequences by waiting on the master's done, checks ack_err, and returns read data or an error status to the requester.
- Lets the game logic and peripheral drivers access I2C slave registers without handling bus phases.

Parameters:
TIMEOUT_CYCLES, 200_000, max clk cycles to wait for m_done after any command pulse before aborting (2 ms at 100 MHz)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request strobe; sampled only when busy=0
req_rw  input  1  0=register write, 1=register read
req_dev  input  7  7-bit slave address
req_reg  input  8  register address
req_wdata  input  8  write data (ignored for reads)
busy  output  1  transaction in progress
rsp_valid  output  1  one-cycle pulse, transaction finished
rsp_err  output  1  valid with rsp_valid: NACK or timeout occurred
rsp_rdata  output  8  valid with rsp_valid: read byte (0 on write or error)
m_start, m_stop, m_write, m_read  output  1 each  one-cycle command pulses to master; at most one high per cycle
m_data_in  output  8  byte for the master's write command; held stable from pulse until m_done
m_ack_in  output  1  ACK bit driven by master after read: 1 (NACK) during RDATA, else 0
m_done  input  1  one-cycle pulse from master, current command complete
m_ack_err  input  1  slave NACK flag, valid in the m_done cycle of a write command
m_data_out  input  8  received byte, valid in the m_done cycle of a read command

Behaviour:
- Reset: state IDLE; busy, rsp_valid, rsp_err, all m_* pulses, m_ack_in = 0; rsp_rdata, m_data_in = 0; latched fields, error flag and timeout counter cleared.
- Reset mid-transaction: abort immediately to IDLE; no STOP issued and no rsp_valid.
- Accept: in IDLE with req=1, latch all req_* fields and set busy=1 on the next edge. req is ignored while busy=1.
- Each command state has two phases:
  - ISSUE: one cycle; asserts exactly one command pulse and loads m_data_in.
  - WAIT: waits for m_done.
  - The next state's ISSUE begins the cycle after m_done.
- Write sequence: START -> ADDR_W (write {dev,0}) -> REG (write reg) -> WDATA (write wdata) -> STOP -> RESP.
- Read sequence: START -> ADDR_W -> REG -> RSTART (repeated m_start) -> ADDR_R (write {dev,1}) -> RDATA (m_read, m_ack_in=1) -> STOP -> RESP.
- RDATA: latch m_data_out into the read register in the m_done cycle.
- NACK: m_done with m_ack_err=1 in ADDR_W, REG, WDATA or ADDR_R sets the error flag and goes to STOP. Remaining data phases are skipped. m_ack_err is ignored in START, RSTART, RDATA and STOP.
- Timeout: counter clears on every ISSUE and increments in WAIT. Reaching TIMEOUT_CYCLES-1 without m_done sets the error flag, then:
  - from STOP, go straight to RESP;
  - from any other state, go to STOP.
- m_done outside WAIT is ignored. m_done in the same cycle the counter hits its limit counts as completion, not timeout.
- RESP: one cycle with rsp_valid=1, busy=0, rsp_err=error flag, rsp_rdata = read byte if (read and no error) else 0. Next state is IDLE.
  - rsp_err and rsp_rdata hold their values until the next rsp_valid.
  - A req present in the RESP cycle is not accepted; accept from IDLE only.
- Latency, write with master done one cycle after each pulse: 10 cycles from the req edge to rsp_valid. Exact cycle counts are checked against this model.

Test Plan:
- Write: dev=0x27, reg=0x10, wdata=0xA5, master model ACKs all -> m_data_in sequence 0x4E, 0x10, 0xA5; pulses start, write×3, stop; rsp_valid once with rsp_err=0, rsp_rdata=0x00.
- Read: dev=0x68, reg=0x75, model returns 0x71 -> bytes 0xD0, 0x75, then repeated start, 0xD1; m_read with m_ack_in=1; rsp_rdata=0x71, rsp_err=0.
- NACK on address byte (m_ack_err=1 on first write done) -> next command is m_stop, no further m_write; rsp_err=1, rsp_rdata=0.
- Timeout: model never returns m_done after m_start, TIMEOUT_CYCLES=50 -> m_stop issued 50 cycles after the ISSUE cycle; master still silent -> rsp_valid with rsp_err=1 after another 50 cycles.
- req pulsed while busy with different fields -> ignored; transaction bytes unchanged; only one rsp_valid.
- reset asserted during REG WAIT -> next cycle busy=0, all m_* pulses 0, no rsp_valid; a fresh write afterwards completes normally.
